// File: rtl/instr_fetch_pkg.sv
// Shared core definitions for the instruction fetch unit: word width, boot address,
// fetch FSM encoding and the buffered entry layout.
package instr_fetch_pkg;

    localparam int WORD_WIDTH = 32;
    localparam logic [WORD_WIDTH-1:0] BOOT_ADDR_DEFAULT = 32'h0000_0080;

    typedef logic [1:0] fetch_state_t;
    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_WAIT_GNT    = 2'd1;
    localparam logic [1:0] ST_WAIT_RVALID = 2'd2;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] addr;
        logic [WORD_WIDTH-1:0] data;
    } fetch_entry_t;

    function automatic logic [WORD_WIDTH-1:0] word_align(input logic [WORD_WIDTH-1:0] a);
        return a & ~WORD_WIDTH'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small register FIFO of {addr, data} fetch entries with flush; pointers carry an
// extra wrap bit so full and empty are distinguishable.
module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  fetch_entry_t             wdata_i,
    input  logic                     pop_i,
    output fetch_entry_t             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem_q [DEPTH];
    fetch_entry_t   mem_d [DEPTH];
    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    logic           do_push;
    logic           do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop_i && !empty_o;
        // A push into a full FIFO is only taken when the same-cycle pop frees the slot.
        do_push  = push_i && (!full_o || do_pop);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q[AW-1:0]] = wdata_i;
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: single-outstanding memory requests feeding a small FIFO to the decoder.
// Define INSTR_FETCH_BYPASS_EN to present returning data to the decoder in the same cycle.
//
// state        | meaning
// ST_IDLE      | no request; waiting for FIFO space
// ST_WAIT_GNT  | request asserted, address held until grant
// ST_WAIT_RVALID | granted, waiting for read data (may be dropped after a branch)
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                    FIFO_DEPTH = 2,
    parameter logic [WORD_WIDTH-1:0] BOOT_ADDR  = BOOT_ADDR_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  instr_req_o,
    output logic [WORD_WIDTH-1:0] instr_addr_o,
    input  logic                  instr_gnt_i,
    input  logic                  instr_rvalid_i,
    input  logic [WORD_WIDTH-1:0] instr_rdata_i,
    input  logic                  branch_i,
    input  logic [WORD_WIDTH-1:0] branch_addr_i,
    output logic [WORD_WIDTH-1:0] instr_o,
    output logic [WORD_WIDTH-1:0] pc_o,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    fetch_state_t          state_q, state_d;
    logic [WORD_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
    logic [WORD_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                  drop_q, drop_d;

    fetch_entry_t          fifo_head;
    fetch_entry_t          out_entry;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [AW:0]           fifo_count;
    logic [AW:0]           fill_after;
    logic                  space_after;
    logic                  rvalid_keep;
    logic                  push;
    logic                  pop;

    // Returning word is kept only if no branch has invalidated it.
    assign rvalid_keep = instr_rvalid_i && (state_q == ST_WAIT_RVALID) && !drop_q && !branch_i;

`ifdef INSTR_FETCH_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit    = fifo_empty && rvalid_keep;
    assign instr_valid_o = !fifo_empty || bypass_hit;
    assign out_entry     = bypass_hit ? '{addr: req_addr_q, data: instr_rdata_i} : fifo_head;
    assign push          = rvalid_keep && !(bypass_hit && instr_ready_i);
`else
    assign instr_valid_o = !fifo_empty;
    assign out_entry     = fifo_head;
    assign push          = rvalid_keep;
`endif

    assign pop          = !fifo_empty && instr_ready_i;
    assign instr_o      = instr_valid_o ? out_entry.data : '0;
    assign pc_o         = instr_valid_o ? out_entry.addr : '0;
    assign instr_req_o  = (state_q == ST_WAIT_GNT);
    assign instr_addr_o = fetch_addr_q;

    assign fill_after  = fifo_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    assign space_after = (fill_after < DEPTH_C);

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (branch_i),
        .push_i  (push),
        .wdata_i ('{addr: req_addr_q, data: instr_rdata_i}),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        req_addr_d   = req_addr_q;
        drop_d       = drop_q;
        case (state_q)
            ST_IDLE: begin
                if (branch_i) begin
                    fetch_addr_d = word_align(branch_addr_i);
                    state_d      = ST_WAIT_GNT;
                end else if (!fifo_full) begin
                    state_d = ST_WAIT_GNT;
                end
            end
            ST_WAIT_GNT: begin
                if (instr_gnt_i) begin
                    req_addr_d = fetch_addr_q;
                    state_d    = ST_WAIT_RVALID;
                    // A branch in the grant cycle still lets this request complete, but its data is stale.
                    if (branch_i) begin
                        fetch_addr_d = word_align(branch_addr_i);
                        drop_d       = 1'b1;
                    end else begin
                        fetch_addr_d = fetch_addr_q + WORD_WIDTH'(4);
                    end
                end else if (branch_i) begin
                    fetch_addr_d = word_align(branch_addr_i);
                    state_d      = ST_IDLE;
                end
            end
            ST_WAIT_RVALID: begin
                if (instr_rvalid_i) begin
                    drop_d  = 1'b0;
                    state_d = (branch_i || space_after) ? ST_WAIT_GNT : ST_IDLE;
                    if (branch_i) begin
                        fetch_addr_d = word_align(branch_addr_i);
                    end
                end else if (branch_i) begin
                    fetch_addr_d = word_align(branch_addr_i);
                    drop_d       = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            fetch_addr_q <= BOOT_ADDR;
            req_addr_q   <= '0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            req_addr_q   <= req_addr_d;
            drop_q       <= drop_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch (default build, FIFO_DEPTH=2) with hand-computed expectations.
module tb_instr_fetch;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    instr_fetch dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .branch_i       (branch_i),
        .branch_addr_i  (branch_addr_i),
        .instr_o        (instr_o),
        .pc_o           (pc_o),
        .instr_valid_o  (instr_valid_o),
        .instr_ready_i  (instr_ready_i)
    );

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    // Grant the pending request for one cycle, then return data the next cycle.
    task automatic fetch_one(input logic [31:0] d);
        instr_gnt_i = 1'b1;
        step();
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = d;
        step();
        instr_rvalid_i = 1'b0;
    endtask

    initial begin
        rst_i          = 1'b1;
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = '0;
        branch_i       = 1'b0;
        branch_addr_i  = '0;
        instr_ready_i  = 1'b1;

        repeat (2) step();
        #1;
        chk1 ("rst_req",   instr_req_o,   1'b0);
        chk1 ("rst_valid", instr_valid_o, 1'b0);
        chk32("rst_instr", instr_o,       32'h0);
        chk32("rst_pc",    pc_o,          32'h0);
        chk32("rst_addr",  instr_addr_o,  32'h0000_0080);
        rst_i = 1'b0;

        step();
        chk1 ("first_req",   instr_req_o,   1'b1);
        chk32("first_addr",  instr_addr_o,  32'h0000_0080);
        chk1 ("first_valid", instr_valid_o, 1'b0);

        // in-order fetch with free-running memory and decoder
        fetch_one(32'hC0DE_0080);
        chk1 ("seq0_valid", instr_valid_o, 1'b1);
        chk32("seq0_pc",    pc_o,          32'h0000_0080);
        chk32("seq0_instr", instr_o,       32'hC0DE_0080);
        chk32("seq0_next",  instr_addr_o,  32'h0000_0084);
        fetch_one(32'hC0DE_0084);
        chk32("seq1_pc",    pc_o,          32'h0000_0084);
        chk32("seq1_instr", instr_o,       32'hC0DE_0084);
        fetch_one(32'hC0DE_0088);
        chk32("seq2_pc",    pc_o,          32'h0000_0088);
        chk32("seq2_instr", instr_o,       32'hC0DE_0088);

        // stalled decoder: two words fill the FIFO and requests stop
        instr_ready_i = 1'b0;
        fetch_one(32'hC0DE_008C);
        chk1 ("full_req",  instr_req_o, 1'b0);
        chk32("full_head", pc_o,        32'h0000_0088);
        for (int i = 0; i < 3; i++) begin
            step();
            chk1 ("full_hold_req", instr_req_o, 1'b0);
        end
        instr_ready_i = 1'b1;
        step();
        chk32("pop1_pc",    pc_o,        32'h0000_008C);
        chk32("pop1_instr", instr_o,     32'hC0DE_008C);
        chk1 ("pop1_req",   instr_req_o, 1'b0);
        step();
        chk1 ("pop2_valid", instr_valid_o, 1'b0);
        chk1 ("pop2_req",   instr_req_o,   1'b1);
        chk32("pop2_addr",  instr_addr_o,  32'h0000_0090);

        // grant withheld: request and address stay put
        for (int i = 0; i < 5; i++) begin
            step();
            chk1 ("hold_req",  instr_req_o,  1'b1);
            chk32("hold_addr", instr_addr_o, 32'h0000_0090);
        end
        fetch_one(32'hC0DE_0090);
        chk32("after_hold_pc", pc_o, 32'h0000_0090);

        // branch while waiting for read data: flush, drop the in-flight word
        instr_ready_i = 1'b0;
        instr_gnt_i   = 1'b1;
        step();
        instr_gnt_i = 1'b0;
        chk1 ("wrv_req",   instr_req_o,   1'b0);
        chk1 ("wrv_valid", instr_valid_o, 1'b1);
        branch_i      = 1'b1;
        branch_addr_i = 32'h0000_1002;
        step();
        branch_i = 1'b0;
        chk1 ("br_flush_valid", instr_valid_o, 1'b0);
        chk1 ("br_req",         instr_req_o,   1'b0);
        chk32("br_addr",        instr_addr_o,  32'h0000_1000);
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = 32'hDEAD_BEEF;
        step();
        instr_rvalid_i = 1'b0;
        chk1 ("drop_valid", instr_valid_o, 1'b0);
        chk1 ("drop_req",   instr_req_o,   1'b1);
        chk32("drop_addr",  instr_addr_o,  32'h0000_1000);
        instr_ready_i = 1'b1;
        fetch_one(32'hC0DE_1000);
        chk32("br_tgt_pc",    pc_o,    32'h0000_1000);
        chk32("br_tgt_instr", instr_o, 32'hC0DE_1000);

        // branch together with rvalid and pop: flush wins
        instr_ready_i = 1'b0;
        instr_gnt_i   = 1'b1;
        step();
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = 32'hC0DE_1004;
        instr_ready_i  = 1'b1;
        branch_i       = 1'b1;
        branch_addr_i  = 32'h0000_2000;
        #1;
        chk32("coll_pre_pc", pc_o, 32'h0000_1000);
        step();
        instr_rvalid_i = 1'b0;
        branch_i       = 1'b0;
        chk1 ("coll_valid", instr_valid_o, 1'b0);
        chk1 ("coll_req",   instr_req_o,   1'b1);
        chk32("coll_addr",  instr_addr_o,  32'h0000_2000);
        step();
        chk1 ("coll_stale", instr_valid_o, 1'b0);
        fetch_one(32'hC0DE_2000);
        chk32("coll_tgt_pc", pc_o, 32'h0000_2000);

        // branch during WAIT_GNT, then address wrap at the top of memory
        branch_i      = 1'b1;
        branch_addr_i = 32'hFFFF_FFFE;
        step();
        branch_i = 1'b0;
        chk1 ("bgnt_req",   instr_req_o,   1'b0);
        chk1 ("bgnt_valid", instr_valid_o, 1'b0);
        chk32("bgnt_addr",  instr_addr_o,  32'hFFFF_FFFC);
        step();
        chk1 ("bgnt_restart", instr_req_o,  1'b1);
        chk32("bgnt_raddr",   instr_addr_o, 32'hFFFF_FFFC);
        fetch_one(32'hC0DE_FFFC);
        chk32("wrap_pc",   pc_o,         32'hFFFF_FFFC);
        chk32("wrap_addr", instr_addr_o, 32'h0000_0000);
        chk1 ("wrap_req",  instr_req_o,  1'b1);

        // reset in the middle of WAIT_GNT
        rst_i = 1'b1;
        #1;
        chk1 ("mrst_req",   instr_req_o,   1'b0);
        chk32("mrst_addr",  instr_addr_o,  32'h0000_0080);
        chk1 ("mrst_valid", instr_valid_o, 1'b0);
        chk32("mrst_pc",    pc_o,          32'h0);
        step();
        rst_i = 1'b0;
        step();
        chk1 ("mrst_restart", instr_req_o,  1'b1);
        chk32("mrst_raddr",   instr_addr_o, 32'h0000_0080);
        fetch_one(32'hC0DE_0A80);
        chk32("mrst_pc_after", pc_o, 32'h0000_0080);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
